// File: rtl/window_ctrl_3x3_if.sv
`default_nettype none
// ============================================================================
// Module   : window_ctrl_3x3_if
// Brief    : Line-buffer, window-register and MAC handshake bundle for the
//            3x3 window sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface window_ctrl_3x3_if #(
   parameter int COL_W = 8,
   parameter int ROW_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             out_ready;
   logic             Wr_window;
   logic             Shift_window;
   logic             Rst_window;
   logic [ROW_W-1:0] in_row;
   logic             win_valid;
   logic [ROW_W-1:0] out_row;
   logic [COL_W-1:0] out_col;

   modport master (
      input  in_valid, out_ready,
      output in_ready, Wr_window, Shift_window, Rst_window,
             in_row, win_valid, out_row, out_col
   );

   modport slave (
      output in_valid, out_ready,
      input  in_ready, Wr_window, Shift_window, Rst_window,
             in_row, win_valid, out_row, out_col
   );
endinterface
`default_nettype wire

// File: rtl/window_ctrl_3x3.sv
`default_nettype none
// ============================================================================
// Module   : window_ctrl_3x3
// Brief    : Frame sequencer for the 3x3 convolution window register
//            (valid-only convolution). Optional backpressure counter is
//            enabled with the WINDOW_CTRL_STALL_CNT_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module window_ctrl_3x3 #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int COL_W = 8,
   parameter int ROW_W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         start,
   window_ctrl_3x3_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [31:0]       stall_cnt
);

   localparam logic [2:0] c_S_IDLE    = 3'd0;
   localparam logic [2:0] c_S_CLEAR   = 3'd1;
   localparam logic [2:0] c_S_FILL    = 3'd2;
   localparam logic [2:0] c_S_RUN     = 3'd3;
   localparam logic [2:0] c_S_ROW_END = 3'd4;
   localparam logic [2:0] c_S_DONE    = 3'd5;

   localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(IMG_H - 3);

   logic [2:0]       r_state;
   logic [2:0]       w_state_next;
   logic [COL_W-1:0] r_in_col;
   logic [COL_W-1:0] r_out_col;
   logic [ROW_W-1:0] r_in_row;
   logic [ROW_W-1:0] r_out_row;
   logic             r_win_valid;

   logic w_can_load;
   logic w_load;
   logic w_win_hs;
   logic w_start_acc;

   // A pending window that the MAC has not taken blocks the next column.
   assign w_can_load  = ((r_state == c_S_FILL) || (r_state == c_S_RUN)) &&
                        (!r_win_valid || bus.out_ready);
   assign w_load      = w_can_load && bus.in_valid;
   assign w_win_hs    = r_win_valid && bus.out_ready;
   assign w_start_acc = (r_state == c_S_IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE:    if (start) w_state_next = c_S_CLEAR;
         c_S_CLEAR:   w_state_next = c_S_FILL;
         c_S_FILL:    if (w_load && (r_in_col == COL_W'(1))) w_state_next = c_S_RUN;
         c_S_RUN:     if (w_load && (r_in_col == c_LAST_COL)) w_state_next = c_S_ROW_END;
         c_S_ROW_END: begin
            // Only the last window of the row can be pending here.
            if (w_win_hs) begin
               w_state_next = (r_out_row == c_LAST_ROW) ? c_S_DONE : c_S_CLEAR;
            end
         end
         c_S_DONE:    w_state_next = c_S_IDLE;
         default:     w_state_next = c_S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready     = w_can_load;
      bus.Wr_window    = w_load;
      bus.Shift_window = w_load;
      bus.Rst_window   = (r_state != c_S_CLEAR);
      busy             = (r_state != c_S_IDLE);
      done             = (r_state == c_S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_col    <= '0;
         r_out_col   <= '0;
         r_in_row    <= '0;
         r_out_row   <= '0;
         r_win_valid <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_in_col    <= '0;
            r_out_col   <= '0;
            r_in_row    <= '0;
            r_out_row   <= '0;
            r_win_valid <= 1'b0;
         end
         if (r_state == c_S_CLEAR) begin
            r_in_col <= '0;
         end
         if (w_load) begin
            r_in_col <= r_in_col + COL_W'(1);
         end
         if (w_load && (r_state == c_S_RUN)) begin
            r_win_valid <= 1'b1;
            r_out_col   <= r_in_col - COL_W'(2);
         end else if (w_win_hs) begin
            r_win_valid <= 1'b0;
         end
         if ((r_state == c_S_ROW_END) && w_win_hs && (r_out_row != c_LAST_ROW)) begin
            r_in_row  <= r_in_row + ROW_W'(1);
            r_out_row <= r_out_row + ROW_W'(1);
         end
      end
   end

   assign bus.in_row    = r_in_row;
   assign bus.out_row   = r_out_row;
   assign bus.out_col   = r_out_col;
   assign bus.win_valid = r_win_valid;

`ifdef WINDOW_CTRL_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_start_acc) begin
         r_stall_cnt <= '0;
      end else if (r_win_valid && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_ctrl_3x3.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_ctrl_3x3
// Brief    : Directed bench: 5x4 frame scenarios plus a minimal 3x3 frame.
// Revision : 1.0  initial release
// ============================================================================
module tb_window_ctrl_3x3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic        busy_a, done_a, busy_b, done_b;
   logic [31:0] stall_a, stall_b;

   window_ctrl_3x3_if #(.COL_W(8), .ROW_W(8)) bus_a ();
   window_ctrl_3x3_if #(.COL_W(8), .ROW_W(8)) bus_b ();

   window_ctrl_3x3 #(.IMG_W(5), .IMG_H(4), .COL_W(8), .ROW_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .bus(bus_a.master),
      .busy(busy_a), .done(done_a), .stall_cnt(stall_a)
   );

   window_ctrl_3x3 #(.IMG_W(3), .IMG_H(3), .COL_W(8), .ROW_W(8)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .bus(bus_b.master),
      .busy(busy_b), .done(done_b), .stall_cnt(stall_b)
   );

   int checks   = 0;
   int failures = 0;

   logic        lg_wv[64], lg_rstw[64], lg_wr[64], lg_sh[64], lg_ir[64], lg_busy[64], lg_done[64];
   logic [7:0]  lg_ocol[64], lg_inrow[64];
   logic [31:0] lg_stall[64];
   int          n_acc;
   int          acc_r[16], acc_c[16];
   int          exp_r[6] = '{0, 0, 0, 1, 1, 1};
   int          exp_c[6] = '{0, 1, 2, 0, 1, 2};

   // Drives one 5x4 frame on dut_a (start in cycle 0) and logs every cycle.
   task automatic run_a(input int mode, input int n);
      n_acc = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         start_a         = (k == 0) || ((mode == 3) && ((k == 5) || (k == 15)));
         bus_a.in_valid  = (mode == 2) ? ((k % 2) == 0) : 1'b1;
         bus_a.out_ready = ((mode == 1) && (k >= 6) && (k <= 9)) ? 1'b0 : 1'b1;
         #1;
         lg_wv[k]    = bus_a.win_valid;
         lg_rstw[k]  = bus_a.Rst_window;
         lg_wr[k]    = bus_a.Wr_window;
         lg_sh[k]    = bus_a.Shift_window;
         lg_ir[k]    = bus_a.in_ready;
         lg_busy[k]  = busy_a;
         lg_done[k]  = done_a;
         lg_ocol[k]  = bus_a.out_col;
         lg_inrow[k] = bus_a.in_row;
         lg_stall[k] = stall_a;
         if (bus_a.win_valid && bus_a.out_ready) begin
            if (n_acc < 16) begin
               acc_r[n_acc] = int'(bus_a.out_row);
               acc_c[n_acc] = int'(bus_a.out_col);
            end
            n_acc++;
         end
      end
      start_a = 1'b0;
   endtask

   task automatic test_reset();
      bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
      bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({bus_a.win_valid, bus_a.Rst_window, bus_a.in_ready, busy_a, done_a, bus_a.Wr_window, bus_a.Shift_window}
          !== 7'b0100000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0100000",
                  {bus_a.win_valid, bus_a.Rst_window, bus_a.in_ready, busy_a, done_a, bus_a.Wr_window, bus_a.Shift_window});
      end
      checks++;
      if ({bus_a.out_row, bus_a.out_col, bus_a.in_row, stall_a} !== 56'd0) begin
         failures++;
         $display("FAIL reset_counters: got %0h expected 0", {bus_a.out_row, bus_a.out_col, bus_a.in_row, stall_a});
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_normal();
      logic [63:0] m_wv, m_done, m_wr, m_rstl, m_busy;
      run_a(0, 20);
      m_wv = '0; m_done = '0; m_wr = '0; m_rstl = '0; m_busy = '0;
      for (int k = 0; k < 20; k++) begin
         m_wv[k] = lg_wv[k]; m_done[k] = lg_done[k]; m_wr[k] = lg_wr[k];
         m_rstl[k] = !lg_rstw[k]; m_busy[k] = lg_busy[k];
      end
      checks++;
      if (m_rstl !== 64'h102) begin failures++; $display("FAIL normal_rst_window_low: got %0h expected 102", m_rstl); end
      checks++;
      if (m_wv !== 64'h70E0) begin failures++; $display("FAIL normal_win_valid: got %0h expected 70e0", m_wv); end
      checks++;
      if (m_wr !== 64'h3E7C) begin failures++; $display("FAIL normal_wr_window: got %0h expected 3e7c", m_wr); end
      checks++;
      if (m_done !== 64'h8000) begin failures++; $display("FAIL normal_done: got %0h expected 8000", m_done); end
      checks++;
      if (m_busy !== 64'hFFFE) begin failures++; $display("FAIL normal_busy: got %0h expected fffe", m_busy); end
      checks++;
      if (lg_inrow[9] !== 8'd1) begin failures++; $display("FAIL normal_in_row: got %0d expected 1", lg_inrow[9]); end
      checks++;
      if (n_acc !== 6) begin failures++; $display("FAIL normal_window_count: got %0d expected 6", n_acc); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ((acc_r[i] !== exp_r[i]) || (acc_c[i] !== exp_c[i])) begin
            failures++;
            $display("FAIL normal_window_%0d: got (%0d,%0d) expected (%0d,%0d)", i, acc_r[i], acc_c[i], exp_r[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] m_wv;
      logic [31:0] exp_stall;
      run_a(1, 24);
      m_wv = '0;
      for (int k = 0; k < 24; k++) m_wv[k] = lg_wv[k];
      for (int k = 6; k <= 9; k++) begin
         checks++;
         if ({lg_ocol[k], lg_ir[k], lg_wr[k], lg_sh[k]} !== {8'd1, 3'b000}) begin
            failures++;
            $display("FAIL stall_hold_c%0d: got col=%0d rdy=%b wr=%b sh=%b expected col=1 rdy=0 wr=0 sh=0",
                     k, lg_ocol[k], lg_ir[k], lg_wr[k], lg_sh[k]);
         end
      end
      checks++;
      if (m_wv !== 64'h70FE0) begin failures++; $display("FAIL stall_win_valid: got %0h expected 70fe0", m_wv); end
      checks++;
      if ((lg_done[19] !== 1'b1) || (lg_done[18] !== 1'b0)) begin
         failures++; $display("FAIL stall_done: got c18=%b c19=%b expected 0 1", lg_done[18], lg_done[19]);
      end
`ifdef WINDOW_CTRL_STALL_CNT_EN
      exp_stall = 32'd4;
`else
      exp_stall = 32'd0;
`endif
      checks++;
      if (lg_stall[23] !== exp_stall) begin failures++; $display("FAIL stall_cnt: got %0d expected %0d", lg_stall[23], exp_stall); end
      checks++;
      if (n_acc !== 6) begin failures++; $display("FAIL stall_window_count: got %0d expected 6", n_acc); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ((acc_r[i] !== exp_r[i]) || (acc_c[i] !== exp_c[i])) begin
            failures++;
            $display("FAIL stall_window_%0d: got (%0d,%0d) expected (%0d,%0d)", i, acc_r[i], acc_c[i], exp_r[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_bubbles();
      int n_wr, n_sh, n_done;
      run_a(2, 60);
      n_wr = 0; n_sh = 0; n_done = 0;
      for (int k = 0; k < 60; k++) begin
         n_wr += int'(lg_wr[k]); n_sh += int'(lg_sh[k]); n_done += int'(lg_done[k]);
      end
      checks++;
      if ((n_wr !== 10) || (n_sh !== 10)) begin failures++; $display("FAIL bubble_pulses: got wr=%0d sh=%0d expected 10 10", n_wr, n_sh); end
      checks++;
      if ((n_done !== 1) || (lg_busy[59] !== 1'b0)) begin
         failures++; $display("FAIL bubble_done: got done=%0d busy=%b expected 1 0", n_done, lg_busy[59]);
      end
      checks++;
      if (n_acc !== 6) begin failures++; $display("FAIL bubble_window_count: got %0d expected 6", n_acc); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ((acc_r[i] !== exp_r[i]) || (acc_c[i] !== exp_c[i])) begin
            failures++;
            $display("FAIL bubble_window_%0d: got (%0d,%0d) expected (%0d,%0d)", i, acc_r[i], acc_c[i], exp_r[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [63:0] m_wv;
      run_a(3, 24);
      m_wv = '0;
      for (int k = 0; k < 24; k++) m_wv[k] = lg_wv[k];
      checks++;
      if (n_acc !== 6) begin failures++; $display("FAIL start_ign_count: got %0d expected 6", n_acc); end
      checks++;
      if (m_wv !== 64'h70E0) begin failures++; $display("FAIL start_ign_win_valid: got %0h expected 70e0", m_wv); end
      checks++;
      if ((lg_busy[16] !== 1'b0) || (lg_busy[23] !== 1'b0)) begin
         failures++; $display("FAIL start_ign_busy: got c16=%b c23=%b expected 0 0", lg_busy[16], lg_busy[23]);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] m_wv;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         start_a = (k == 0); bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
         if (k == 6) rst = 1'b1;
         #1;
      end
      checks++;
      if ({bus_a.win_valid, bus_a.Rst_window, bus_a.in_ready, busy_a, done_a, bus_a.Wr_window, bus_a.Shift_window}
          !== 7'b0100000) begin
         failures++;
         $display("FAIL midrst_flags: got %b expected 0100000",
                  {bus_a.win_valid, bus_a.Rst_window, bus_a.in_ready, busy_a, done_a, bus_a.Wr_window, bus_a.Shift_window});
      end
      checks++;
      if ({bus_a.out_row, bus_a.out_col, bus_a.in_row} !== 24'd0) begin
         failures++; $display("FAIL midrst_counters: got %0h expected 0", {bus_a.out_row, bus_a.out_col, bus_a.in_row});
      end
      @(negedge clk); rst = 1'b0;
      run_a(0, 20);
      m_wv = '0;
      for (int k = 0; k < 20; k++) m_wv[k] = lg_wv[k];
      checks++;
      if ((n_acc !== 6) || (m_wv !== 64'h70E0)) begin
         failures++; $display("FAIL midrst_restart: got count=%0d wv=%0h expected 6 70e0", n_acc, m_wv);
      end
   endtask

   task automatic test_min_frame();
      logic [63:0] m_wv, m_done;
      logic [15:0] idx5;
      m_wv = '0; m_done = '0; idx5 = 16'hFFFF;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start_b = (k == 0); bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
         #1;
         m_wv[k] = bus_b.win_valid; m_done[k] = done_b;
         if (k == 5) idx5 = {bus_b.out_row, bus_b.out_col};
      end
      start_b = 1'b0;
      checks++;
      if (m_wv !== 64'h20) begin failures++; $display("FAIL min_win_valid: got %0h expected 20", m_wv); end
      checks++;
      if (idx5 !== 16'h0000) begin failures++; $display("FAIL min_index: got %0h expected 0000", idx5); end
      checks++;
      if (m_done !== 64'h40) begin failures++; $display("FAIL min_done: got %0h expected 40", m_done); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_backpressure();
      test_bubbles();
      test_start_ignored();
      test_reset_mid();
      test_min_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
